// File: rtl/uart_responder_pkg.sv
// Shared types and defaults for the UART responder and its receive core.
package uart_responder_pkg;

   localparam int DATA_BUS         = 16;
   localparam int CLKS_PER_BIT_DEF = 96;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Bit-time down-counter width; must hold CLKS_PER_BIT-1.
   function automatic int tmr_width(input int cpb);
      return (cpb < 2) ? 1 : $clog2(cpb);
   endfunction

endpackage

// File: rtl/uart_responder_rx.sv
// Receive core: rxd synchroniser, 8N1 deserialiser, byte/frame-error strobes.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for synchronised rxd low
// RX_START | timing to the start-bit centre, rejecting false starts
// RX_DATA  | sampling 8 data bits LSB first at bit centres
// RX_STOP  | timing to the stop-bit centre
module uart_rx_core
   import uart_responder_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int            TW        = tmr_width(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    sync;
   logic          rxs;
   rx_state_t     state;
   logic [TW-1:0] tmr;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          stop_tc;

   assign rxs = sync[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync    <= 2'b11;
         state   <= RX_IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         sync <= {sync[0], rxd};
         case (state)
            RX_IDLE: begin
               if (!rxs) begin
                  tmr   <= HALF_LAST;
                  state <= RX_START;
               end
            end
            RX_START: begin
               if (tmr == '0) begin
                  tmr     <= BIT_LAST;
                  bit_idx <= 3'd7;
                  state   <= rxs ? RX_IDLE : RX_DATA;
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end
            RX_DATA: begin
               if (tmr == '0) begin
                  tmr   <= BIT_LAST;
                  shift <= {rxs, shift[7:1]};
                  if (bit_idx == 3'd0) state <= RX_STOP;
                  else                 bit_idx <= bit_idx - 3'd1;
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end
            RX_STOP: begin
               if (tmr == '0) state <= RX_IDLE;
               else           tmr   <= tmr - TW'(1);
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // Strobes are decoded from registered state so they last exactly one cycle.
   assign stop_tc    = (state == RX_STOP) && (tmr == '0);
   assign byte_valid = stop_tc && rxs;
   assign frame_err  = stop_tc && !rxs;
   assign rx_byte    = shift;

endmodule

// File: rtl/uart_responder.sv
// Bus-side UART responder: write strobe -> 8N1 transmitter, receive buffer on read.
//
// state    | meaning
// TX_IDLE  | shifter idle; loads from hold when hold_full
// TX_START | driving start bit for one bit time
// TX_DATA  | driving 8 data bits LSB first
// TX_STOP  | driving stop bit for one bit time
module uart_responder
   import uart_responder_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_W       = DATA_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrn,
   input  logic              rdn,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              tbre,
   output logic              tsre,
   output logic              data_ready,
   output logic              txd,
   input  logic              rxd,
   output logic              overrun,
   output logic              frame_err
);

   localparam int            TW       = tmr_width(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

   logic          wrn_q, rdn_q;
   logic          write_ev, read_ev;
   logic [7:0]    hold;
   logic          hold_full;
   tx_state_t     tx_state;
   logic [TW-1:0] tx_tmr;
   logic [2:0]    tx_bits;
   logic [7:0]    tx_shift;
   logic [7:0]    rx_buf;
   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic          unused_data_hi;

   assign write_ev       = !wrn_q && wrn;
   assign read_ev        = !rdn_q && rdn;
   assign tbre           = !hold_full;
   assign tsre           = (tx_state == TX_IDLE);
   assign data_oe        = !rst && !rdn;
   assign data_out       = {{(DATA_W-8){1'b0}}, rx_buf};
   assign unused_data_hi = ^data_in[DATA_W-1:8];

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wrn_q      <= 1'b1;
         rdn_q      <= 1'b1;
         hold       <= '0;
         hold_full  <= 1'b0;
         tx_state   <= TX_IDLE;
         tx_tmr     <= '0;
         tx_bits    <= '0;
         tx_shift   <= '0;
         txd        <= 1'b1;
         rx_buf     <= '0;
         data_ready <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         wrn_q <= wrn;
         rdn_q <= rdn;

         // Acceptance uses hold_full before this edge, so a write coinciding
         // with the IDLE load is dropped while the load takes the old byte.
         if (write_ev && !hold_full) begin
            hold      <= data_in[7:0];
            hold_full <= 1'b1;
         end

         case (tx_state)
            TX_IDLE: begin
               if (hold_full) begin
                  tx_shift  <= hold;
                  hold_full <= 1'b0;
                  tx_tmr    <= BIT_LAST;
                  txd       <= 1'b0;
                  tx_state  <= TX_START;
               end
            end
            TX_START: begin
               if (tx_tmr == '0) begin
                  tx_tmr   <= BIT_LAST;
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bits  <= 3'd7;
                  tx_state <= TX_DATA;
               end else begin
                  tx_tmr <= tx_tmr - TW'(1);
               end
            end
            TX_DATA: begin
               if (tx_tmr == '0) begin
                  tx_tmr <= BIT_LAST;
                  if (tx_bits == 3'd0) begin
                     txd      <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bits  <= tx_bits - 3'd1;
                  end
               end else begin
                  tx_tmr <= tx_tmr - TW'(1);
               end
            end
            TX_STOP: begin
               if (tx_tmr == '0) tx_state <= TX_IDLE;
               else              tx_tmr   <= tx_tmr - TW'(1);
            end
            default: tx_state <= TX_IDLE;
         endcase

         // A new byte beats a coincident read-end and is not an overrun.
         if (byte_valid) begin
            rx_buf     <= rx_byte;
            data_ready <= 1'b1;
         end else if (read_ev) begin
            data_ready <= 1'b0;
         end
         overrun <= byte_valid && data_ready && !read_ev;
      end
   end

endmodule

// File: tb/tb_uart_responder.sv
// Self-checking bench for uart_responder with a behavioural serial line model.
module tb_uart_responder;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst, wrn, rdn, rxd;
   logic [15:0] data_in, data_out;
   logic        data_oe, tbre, tsre, data_ready, txd, overrun, frame_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   logic [7:0] mon_byte[$];
   logic       mon_stop[$];
   int         mon_fall[$];

   uart_responder #(.CLKS_PER_BIT(CPB), .DATA_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .wrn        (wrn),
      .rdn        (rdn),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .tbre       (tbre),
      .tsre       (tsre),
      .data_ready (data_ready),
      .txd        (txd),
      .rxd        (rxd),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
   end

   // Line receiver: samples txd at bit centres, records byte, stop bit and fall cycle.
   initial begin
      logic [7:0] mb;
      logic       ms;
      int         tf;
      forever begin
         @(negedge clk);
         if (txd === 1'b0 && rst === 1'b0) begin
            tf = cyc;
            repeat (CPB/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mb[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            ms = txd;
            mon_byte.push_back(mb);
            mon_stop.push_back(ms);
            mon_fall.push_back(tf);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_write(input logic [15:0] d);
      data_in = d;
      wrn     = 1'b0;
      wait_neg(2);
      wrn     = 1'b1;
      wait_neg(1);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         wait_neg(CPB);
      end
      rxd = 1'b1;
   endtask

   task automatic do_read();
      rdn = 1'b0;
      wait_neg(2);
      rdn = 1'b1;
      wait_neg(2);
   endtask

   task automatic test_reset();
      rst = 1'b1; wrn = 1'b1; rdn = 1'b0; rxd = 1'b1; data_in = '0;
      wait_neg(3);
      checks++;
      if ({txd, tbre, tsre, data_ready, data_oe, overrun, frame_err} !== 7'b1110000) begin
         errors++;
         $display("FAIL reset_in_rst: got %b want 1110000", {txd, tbre, tsre, data_ready, data_oe, overrun, frame_err});
      end
      rdn = 1'b1; rst = 1'b0;
      wait_neg(2);
      checks++;
      if ({txd, tbre, tsre, data_ready, data_oe, overrun, frame_err, data_out} !== {7'b1110000, 16'h0000}) begin
         errors++;
         $display("FAIL reset_after: got %b/%h want 1110000/0000", {txd, tbre, tsre, data_ready, data_oe, overrun, frame_err}, data_out);
      end
   endtask

   task automatic test_tx_single();
      logic [9:0] fr;
      fr = {1'b1, 8'hA5, 1'b0};
      mon_byte.delete(); mon_stop.delete(); mon_fall.delete();
      do_write(16'h00A5);
      checks++;
      if ({tbre, tsre, txd} !== 3'b011) begin
         errors++;
         $display("FAIL tx_after_write: tbre/tsre/txd got %b want 011", {tbre, tsre, txd});
      end
      wait_neg(1);
      checks++;
      if ({tbre, tsre, txd} !== 3'b100) begin
         errors++;
         $display("FAIL tx_start: tbre/tsre/txd got %b want 100", {tbre, tsre, txd});
      end
      for (int k = 0; k < 10*CPB; k++) begin
         checks++;
         if ({tsre, txd} !== {1'b0, fr[k/CPB]}) begin
            errors++;
            $display("FAIL tx_wave cycle %0d: tsre/txd got %b want %b", k, {tsre, txd}, {1'b0, fr[k/CPB]});
         end
         wait_neg(1);
      end
      checks++;
      if (tsre !== 1'b1) begin
         errors++;
         $display("FAIL tx_tsre_end: got %b want 1", tsre);
      end
      wait_neg(2);
   endtask

   task automatic test_back_to_back();
      int n;
      mon_byte.delete(); mon_stop.delete(); mon_fall.delete();
      do_write(16'h0011);
      n = 0;
      while (tbre !== 1'b1 && n < 100) begin wait_neg(1); n++; end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL b2b_tbre_timeout: tbre got %b want 1", tbre); end
      do_write(16'h0022);
      checks++;
      if (tbre !== 1'b0) begin errors++; $display("FAIL b2b_second_held: tbre got %b want 0", tbre); end
      do_write(16'h0033);
      n = 0;
      while (mon_byte.size() < 2 && n < 200) begin wait_neg(1); n++; end
      wait_neg(60);
      checks++;
      if (mon_byte.size() != 2) begin
         errors++;
         $display("FAIL b2b_frame_count: got %0d want 2", mon_byte.size());
      end else begin
         checks++;
         if ({mon_byte[0], mon_byte[1], mon_stop[0], mon_stop[1]} !== {8'h11, 8'h22, 2'b11}) begin
            errors++;
            $display("FAIL b2b_bytes: got %h %h stop %b%b want 11 22 stop 11", mon_byte[0], mon_byte[1], mon_stop[0], mon_stop[1]);
         end
         checks++;
         if (mon_fall[1] - mon_fall[0] < 10*CPB || mon_fall[1] - mon_fall[0] > 10*CPB + 1) begin
            errors++;
            $display("FAIL b2b_gap: frame spacing got %0d want %0d..%0d", mon_fall[1] - mon_fall[0], 10*CPB, 10*CPB + 1);
         end
      end
   endtask

   task automatic test_random_tx();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int n;
      mon_byte.delete(); mon_stop.delete(); mon_fall.delete();
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (tbre !== 1'b1 && n < 100) begin wait_neg(1); n++; end
         checks++;
         if (n >= 100) begin errors++; $display("FAIL rtx_tbre_timeout %0d: tbre got %b want 1", i, tbre); end
         b = 8'($urandom);
         exp_q.push_back(b);
         do_write({8'($urandom), b});
      end
      n = 0;
      while (mon_byte.size() < 6 && n < 600) begin wait_neg(1); n++; end
      checks++;
      if (mon_byte.size() != 6) begin
         errors++;
         $display("FAIL rtx_count: got %0d want 6", mon_byte.size());
      end
      while (exp_q.size() > 0 && mon_byte.size() > 0) begin
         checks++;
         if ({mon_byte[0], mon_stop[0]} !== {exp_q[0], 1'b1}) begin
            errors++;
            $display("FAIL rtx_byte: got %h stop %b want %h stop 1", mon_byte[0], mon_stop[0], exp_q[0]);
         end
         void'(mon_byte.pop_front()); void'(mon_stop.pop_front()); void'(exp_q.pop_front());
      end
      wait_neg(2 * CPB);
   endtask

   task automatic test_rx_read();
      send_rx(8'h3C, 1'b1);
      wait_neg(3);
      checks++;
      if (data_ready !== 1'b1) begin errors++; $display("FAIL rx_ready: got %b want 1", data_ready); end
      rdn = 1'b0;
      #1;
      checks++;
      if ({data_oe, data_out} !== {1'b1, 16'h003C}) begin
         errors++;
         $display("FAIL rx_bus: oe/data got %b/%h want 1/003c", data_oe, data_out);
      end
      wait_neg(2);
      rdn = 1'b1;
      wait_neg(2);
      checks++;
      if ({data_ready, data_oe} !== 2'b00) begin
         errors++;
         $display("FAIL rx_read_clear: ready/oe got %b want 00", {data_ready, data_oe});
      end
   endtask

   task automatic test_overrun();
      int base;
      base = ov_cnt;
      send_rx(8'h01, 1'b1);
      wait_neg(3);
      send_rx(8'h02, 1'b1);
      wait_neg(4);
      checks++;
      if (ov_cnt - base !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - base); end
      checks++;
      if ({data_ready, data_out} !== {1'b1, 16'h0002}) begin
         errors++;
         $display("FAIL overrun_data: ready/data got %b/%h want 1/0002", data_ready, data_out);
      end
      do_read();
   endtask

   task automatic test_frame_err();
      int base;
      send_rx(8'h77, 1'b1);
      wait_neg(3);
      base = fe_cnt;
      send_rx(8'hAA, 1'b0);
      wait_neg(6);
      checks++;
      if (fe_cnt - base !== 1) begin errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - base); end
      checks++;
      if ({data_ready, data_out} !== {1'b1, 16'h0077}) begin
         errors++;
         $display("FAIL frame_err_keep: ready/data got %b/%h want 1/0077", data_ready, data_out);
      end
      rxd = 1'b0;
      wait_neg(1);
      rxd = 1'b1;
      wait_neg(12 * CPB);
      checks++;
      if ({fe_cnt - base, data_ready, data_out} !== {32'd1, 1'b1, 16'h0077}) begin
         errors++;
         $display("FAIL glitch: fe/ready/data got %0d/%b/%h want 1/1/0077", fe_cnt - base, data_ready, data_out);
      end
      do_read();
   endtask

   task automatic test_random_rx();
      logic [7:0] b;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         wait_neg($urandom_range(0, 5));
         send_rx(b, 1'b1);
         wait_neg(3);
         checks++;
         if ({data_ready, data_out} !== {1'b1, 8'h00, b}) begin
            errors++;
            $display("FAIL rrx_byte %0d: ready/data got %b/%h want 1/%h", i, data_ready, data_out, {8'h00, b});
         end
         do_read();
         checks++;
         if (data_ready !== 1'b0) begin errors++; $display("FAIL rrx_clear %0d: got %b want 0", i, data_ready); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      send_rx(8'h5A, 1'b1);
      wait_neg(3);
      do_write(16'h0096);
      wait_neg(10);
      rxd = 1'b0;
      wait_neg(CPB + 2);
      rxd = 1'b1;
      wait_neg(3);
      rst = 1'b1;
      rdn = 1'b0;
      wait_neg(1);
      checks++;
      if ({txd, tbre, tsre, data_ready, data_oe, overrun, frame_err, data_out} !== {7'b1110000, 16'h0000}) begin
         errors++;
         $display("FAIL reset_mid: got %b/%h want 1110000/0000", {txd, tbre, tsre, data_ready, data_oe, overrun, frame_err}, data_out);
      end
      rst = 1'b0;
      rdn = 1'b1;
      wait_neg(12 * CPB);
      checks++;
      if ({data_ready, txd, tsre} !== 3'b011) begin
         errors++;
         $display("FAIL reset_mid_after: ready/txd/tsre got %b want 011", {data_ready, txd, tsre});
      end
      mon_byte.delete(); mon_stop.delete(); mon_fall.delete();
      do_write(16'h00C3);
      n = 0;
      while (mon_byte.size() < 1 && n < 200) begin wait_neg(1); n++; end
      checks++;
      if (mon_byte.size() != 1) begin
         errors++;
         $display("FAIL reset_retx_count: got %0d want 1", mon_byte.size());
      end else begin
         checks++;
         if ({mon_byte[0], mon_stop[0]} !== {8'hC3, 1'b1}) begin
            errors++;
            $display("FAIL reset_retx_byte: got %h stop %b want c3 stop 1", mon_byte[0], mon_stop[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_random_tx();
      test_rx_read();
      test_overrun();
      test_frame_err();
      test_random_rx();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
